nios2_oci_itrace_dct_packer: RTL and testbench

- Upstream feeder of the OCI trace test bench and the trace FIFO.
- Packs 2-bit direct-control-transfer (DCT) codes from the retiring instruction stream into a 30-bit shift buffer with a 4-bit occupancy count.
- Emits a 36-bit trace frame downstream when the buffer fills or a flush is requested.
- Exposes `dct_buffer` and `dct_count` for the simulation-only OCI test bench.

---
 rtl/nios2_oci_itrace_dct_packer_pkg.sv | 22 ++
 rtl/nios2_oci_itrace_dct_packer_if.sv | 22 ++
 rtl/nios2_oci_itrace_dct_packer_skid_reg.sv | 30 +++
 rtl/nios2_oci_itrace_dct_packer.sv | 114 +++++++++++
 tb/tb_nios2_oci_itrace_dct_packer.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/nios2_oci_itrace_dct_packer_pkg.sv
// Shared trace definitions: frame types, DCT code values, packer FSM states
// and default geometry for the OCI instruction/data trace packers.
package nios2_oci_trace_pkg;

    localparam int DEF_DCT_SLOTS = 15;
    localparam int DEF_FRM_W     = 2 + 4 + 2 * DEF_DCT_SLOTS;

    localparam logic [1:0] FRM_TYPE_FULL  = 2'b01;
    localparam logic [1:0] FRM_TYPE_FLUSH = 2'b10;

    localparam logic [1:0] DCT_RSVD      = 2'b00;
    localparam logic [1:0] DCT_TAKEN     = 2'b01;
    localparam logic [1:0] DCT_NOT_TAKEN = 2'b10;
    localparam logic [1:0] DCT_ERET      = 2'b11;

    typedef enum logic [1:0] {
        EMPTY,
        ACCUM,
        STALL
    } pack_state_t;

endpackage

// File: rtl/nios2_oci_itrace_dct_packer_if.sv
// DCT code input handshake plus trace frame output handshake of the packer.
interface nios2_oci_itrace_dct_packer_if #(
    parameter int FRM_W = nios2_oci_trace_pkg::DEF_FRM_W
);
    logic             dct_valid;
    logic [1:0]       dct_code;
    logic             flush;
    logic             dct_ready;
    logic             frm_valid;
    logic             frm_ready;
    logic [FRM_W-1:0] frm_data;

    modport master (
        output dct_valid, dct_code, flush, frm_ready,
        input  dct_ready, frm_valid, frm_data
    );

    modport slave (
        input  dct_valid, dct_code, flush, frm_ready,
        output dct_ready, frm_valid, frm_data
    );
endinterface

// File: rtl/nios2_oci_itrace_dct_packer_skid_reg.sv
// One-entry valid/ready output register shared by the itrace and dtrace paths.
module nios2_oci_trace_skid_reg #(
    parameter int W = nios2_oci_trace_pkg::DEF_FRM_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic         can_load,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign can_load = !out_valid || out_ready;

    // Data only changes on a load, so it stays put while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load && can_load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/nios2_oci_itrace_dct_packer.sv
// Packs 2-bit DCT codes into a shift buffer and emits full or flushed
// trace frames through a one-entry output register.
module nios2_oci_itrace_dct_packer
    import nios2_oci_trace_pkg::*;
#(
    parameter int DCT_SLOTS = nios2_oci_trace_pkg::DEF_DCT_SLOTS,
    parameter int FRM_W     = nios2_oci_trace_pkg::DEF_FRM_W
) (
    input  logic                   clk,
    input  logic                   jrst_n,
    input  logic                   trc_on,
    nios2_oci_itrace_dct_packer_if.slave bus,
    output logic [2*DCT_SLOTS-1:0] dct_buffer,
    output logic [3:0]             dct_count
);

    localparam int         BUF_W    = 2 * DCT_SLOTS;
    localparam logic [3:0] FULL_CNT = 4'(DCT_SLOTS);

    pack_state_t      state_q, state_d;
    logic [BUF_W-1:0] shift_q, shift_d, post_shift;
    logic [3:0]       cnt_q, cnt_d, post_cnt;
    logic [1:0]       pend_type_q, pend_type_d, emit_type;
    logic             ins, full_emit, flush_emit;
    logic             load, can_load;
    logic [FRM_W-1:0] load_data;

    assign bus.dct_ready = (state_q != STALL);
    assign dct_buffer    = shift_q;
    assign dct_count     = cnt_q;

    // A simultaneous code and flush is inserted first, so the flush sees it.
    always_comb begin
        ins        = bus.dct_valid && bus.dct_ready && trc_on && (bus.dct_code != DCT_RSVD);
        post_shift = ins ? {bus.dct_code, shift_q[BUF_W-1:2]} : shift_q;
        post_cnt   = cnt_q + 4'(ins);
        full_emit  = ins && (post_cnt == FULL_CNT);
        flush_emit = bus.flush && bus.dct_ready && trc_on && (post_cnt != 4'd0) && !full_emit;
        emit_type  = full_emit ? FRM_TYPE_FULL : FRM_TYPE_FLUSH;
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = post_shift;
        cnt_d       = post_cnt;
        pend_type_d = pend_type_q;
        load        = 1'b0;
        load_data   = {emit_type, post_cnt, post_shift};
        case (state_q)
            STALL: begin
                shift_d   = shift_q;
                cnt_d     = cnt_q;
                load_data = {pend_type_q, cnt_q, shift_q};
                if (!trc_on) begin
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = EMPTY;
                end else if (can_load) begin
                    load    = 1'b1;
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = EMPTY;
                end
            end
            default: begin
                if (!trc_on) begin
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = EMPTY;
                end else if (full_emit || flush_emit) begin
                    if (can_load) begin
                        load    = 1'b1;
                        shift_d = '0;
                        cnt_d   = '0;
                        state_d = EMPTY;
                    end else begin
                        pend_type_d = emit_type;
                        state_d     = STALL;
                    end
                end else begin
                    state_d = (post_cnt != 4'd0) ? ACCUM : EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge jrst_n) begin
        if (!jrst_n) begin
            state_q     <= EMPTY;
            shift_q     <= '0;
            cnt_q       <= '0;
            pend_type_q <= FRM_TYPE_FULL;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            pend_type_q <= pend_type_d;
        end
    end

    nios2_oci_trace_skid_reg #(
        .W (FRM_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (jrst_n),
        .load      (load),
        .load_data (load_data),
        .can_load  (can_load),
        .out_valid (bus.frm_valid),
        .out_ready (bus.frm_ready),
        .out_data  (bus.frm_data)
    );

endmodule

// File: tb/tb_nios2_oci_itrace_dct_packer.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based model of the packer and its output register.
module tb_nios2_oci_itrace_dct_packer;
    import nios2_oci_trace_pkg::*;

    logic        clk    = 1'b0;
    logic        jrst_n = 1'b0;
    logic        trc_on = 1'b0;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;

    int checks = 0;
    int errors = 0;

    logic [1:0]  m_codes[$];
    bit          m_stall = 1'b0;
    logic [1:0]  m_ptype = 2'b00;
    bit          m_ov    = 1'b0;
    logic [35:0] m_od    = '0;

    nios2_oci_itrace_dct_packer_if bus ();

    nios2_oci_itrace_dct_packer dut (
        .clk        (clk),
        .jrst_n     (jrst_n),
        .trc_on     (trc_on),
        .bus        (bus),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count)
    );

    always #5 clk = ~clk;

    // Oldest code sits lowest; the newest always occupies bits [29:28].
    function automatic logic [29:0] packCodes();
        logic [29:0] b = '0;
        int n = m_codes.size();
        for (int i = 0; i < n; i++)
            b = b | (30'(m_codes[i]) << (2 * (15 - n + i)));
        return b;
    endfunction

    task automatic checkOutput(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_codes.delete();
        m_stall = 1'b0;
        m_ov    = 1'b0;
        m_od    = '0;
    endtask

    // Check the current cycle, drive new inputs, advance the model one edge.
    task automatic applyStimulus(input bit tv, input bit v, input logic [1:0] c,
                                 input bit f, input bit r);
        bit          can_load;
        bit          n_ov;
        bit          emit;
        logic [1:0]  t;
        logic [35:0] n_od;
        @(negedge clk);
        checkOutput("dct_ready", 36'(bus.dct_ready), 36'(!m_stall));
        checkOutput("dct_count", 36'(dct_count), 36'(m_codes.size()));
        checkOutput("dct_buffer", 36'(dct_buffer), 36'(packCodes()));
        checkOutput("frm_valid", 36'(bus.frm_valid), 36'(m_ov));
        checkOutput("frm_data", bus.frm_data, m_od);
        trc_on        = tv;
        bus.dct_valid = v;
        bus.dct_code  = c;
        bus.flush     = f;
        bus.frm_ready = r;
        can_load = !m_ov || r;
        n_ov     = m_ov && !r;
        n_od     = m_od;
        emit     = 1'b0;
        t        = FRM_TYPE_FLUSH;
        if (!tv) begin
            m_codes.delete();
            m_stall = 1'b0;
        end else if (m_stall) begin
            if (r) begin
                n_ov = 1'b1;
                n_od = {m_ptype, 4'(m_codes.size()), packCodes()};
                m_codes.delete();
                m_stall = 1'b0;
            end
        end else begin
            if (v && c != 2'b00) begin
                m_codes.push_back(c);
                if (m_codes.size() == 15) begin
                    emit = 1'b1;
                    t    = FRM_TYPE_FULL;
                end
            end
            if (!emit && f && m_codes.size() > 0)
                emit = 1'b1;
            if (emit) begin
                if (can_load) begin
                    n_ov = 1'b1;
                    n_od = {t, 4'(m_codes.size()), packCodes()};
                    m_codes.delete();
                end else begin
                    m_stall = 1'b1;
                    m_ptype = t;
                end
            end
        end
        m_ov = n_ov;
        m_od = n_od;
        @(posedge clk);
    endtask

    initial begin
        logic [35:0] exp_frame;
        bit          v = 1'b0;
        bit          f = 1'b0;
        logic [1:0]  c = 2'b00;
        bus.dct_valid = 1'b0;
        bus.dct_code  = 2'b00;
        bus.flush     = 1'b0;
        bus.frm_ready = 1'b0;
        modelReset();

        repeat (2) applyStimulus(0, 0, 2'b00, 0, 0);
        jrst_n = 1'b1;
        applyStimulus(1, 0, 2'b00, 0, 1);

        // Fifteen taken codes make exactly one full frame.
        repeat (15) applyStimulus(1, 1, DCT_TAKEN, 0, 1);
        #1 checkOutput("full_frame_const", bus.frm_data, 36'h7D5555555);
        applyStimulus(1, 0, 2'b00, 0, 1);

        applyStimulus(1, 1, DCT_TAKEN, 0, 1);
        applyStimulus(1, 1, DCT_NOT_TAKEN, 0, 1);
        applyStimulus(1, 1, DCT_ERET, 0, 1);
        applyStimulus(1, 0, 2'b00, 1, 1);
        exp_frame = {2'b10, 4'd3, 6'b111001, 24'd0};
        #1 checkOutput("flush_frame_const", bus.frm_data, exp_frame);
        repeat (2) applyStimulus(1, 0, 2'b00, 0, 1);

        // Two frames' worth with the consumer blocked, then drain.
        repeat (30) applyStimulus(1, 1, DCT_TAKEN, 0, 0);
        repeat (3) applyStimulus(1, 0, 2'b00, 0, 0);
        repeat (3) applyStimulus(1, 0, 2'b00, 0, 1);

        repeat (14) applyStimulus(1, 1, DCT_NOT_TAKEN, 0, 1);
        applyStimulus(1, 1, DCT_ERET, 1, 1);
        repeat (2) applyStimulus(1, 0, 2'b00, 0, 1);

        repeat (7) applyStimulus(1, 1, DCT_ERET, 0, 1);
        applyStimulus(0, 0, 2'b00, 0, 1);
        repeat (2) applyStimulus(1, 0, 2'b00, 0, 1);

        repeat (30) applyStimulus(1, 1, DCT_TAKEN, 0, 0);
        applyStimulus(0, 0, 2'b00, 0, 0);
        repeat (3) applyStimulus(1, 0, 2'b00, 0, 1);

        repeat (2) applyStimulus(1, 0, 2'b00, 1, 1);

        // Asynchronous reset while stalled with a full output register.
        repeat (30) applyStimulus(1, 1, DCT_NOT_TAKEN, 0, 0);
        applyStimulus(1, 0, 2'b00, 0, 0);
        #2 jrst_n = 1'b0;
        #1;
        checkOutput("rst_dct_ready", 36'(bus.dct_ready), 36'd1);
        checkOutput("rst_dct_count", 36'(dct_count), 36'd0);
        checkOutput("rst_dct_buffer", 36'(dct_buffer), 36'd0);
        checkOutput("rst_frm_valid", 36'(bus.frm_valid), 36'd0);
        checkOutput("rst_frm_data", bus.frm_data, 36'd0);
        modelReset();
        applyStimulus(0, 0, 2'b00, 0, 0);
        #1 jrst_n = 1'b1;
        applyStimulus(1, 0, 2'b00, 0, 1);

        // Random traffic; offers are held stable while the packer stalls.
        for (int i = 0; i < 3000; i++) begin
            if (!m_stall) begin
                v = ($urandom_range(0, 3) != 0);
                c = 2'($urandom);
                f = ($urandom_range(0, 15) == 0);
            end
            applyStimulus(($urandom_range(0, 99) != 0), v, c, f,
                          ($urandom_range(0, 9) < 7));
        end
        applyStimulus(1, 0, 2'b00, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
